// File: rtl/tag_pool_alloc.sv
// Physical-tag free-list allocator: circular FIFO of free tags, filled at init.
// Optional retire protocol checking enabled by defining TAG_POOL_CHECK_EN.
module tag_pool_alloc #(
    parameter int tag_w    = 6,
    parameter bit embedded = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             AllocValid,
    input  logic             AllocReady,
    output logic [tag_w-1:0] AllocTag,
    input  logic             RetireEnable,
    input  logic [tag_w-1:0] RetireTag,
    output logic [tag_w:0]   FreeCount,
    output logic             InitDone,
    output logic             RetireErr
);

    localparam int DEPTH    = 2**tag_w;
    localparam int NREG     = embedded ? 16 : 32;
    localparam int FREE_MAX = DEPTH - NREG;

    localparam logic [tag_w-1:0] TAG_FIRST = tag_w'(NREG);
    localparam logic [tag_w-1:0] TAG_LAST  = tag_w'(DEPTH - 1);
    localparam logic [tag_w:0]   CNT_MAX   = (tag_w+1)'(FREE_MAX);
    localparam logic [tag_w:0]   CNT_ONE   = (tag_w+1)'(1);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t           r_state;
    logic [tag_w-1:0] r_mem [DEPTH];
    logic [tag_w-1:0] r_rd_ptr;
    logic [tag_w-1:0] r_wr_ptr;
    logic [tag_w-1:0] r_init_cnt;
    logic [tag_w:0]   r_free_cnt;
    logic             r_alloc_valid;
    logic             r_init_done;

    logic             w_run;
    logic             w_fire;
    logic             w_retire;
    logic             w_full;
    logic             w_we;
    logic [tag_w-1:0] w_wdata;
    logic [tag_w:0]   w_cnt_nxt;

    assign w_run  = (r_state == S_RUN);
    assign w_fire = r_alloc_valid & AllocReady;
    assign w_full = (r_free_cnt == CNT_MAX);

`ifdef TAG_POOL_CHECK_EN
    logic [DEPTH-1:0] r_busy;
    logic             r_err;
    logic             w_bad;

    // Busy state is sampled before this cycle's alloc updates it.
    assign w_retire = RetireEnable & w_run & r_busy[RetireTag] & ~w_full;
    assign w_bad    = RetireEnable & ~w_retire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_busy[i] <= (i < NREG);
            end
            r_err <= 1'b0;
        end else begin
            if (w_fire) begin
                r_busy[AllocTag] <= 1'b1;
            end
            if (w_retire) begin
                r_busy[RetireTag] <= 1'b0;
            end
            r_err <= w_bad;
        end
    end

    assign RetireErr = r_err;
`else
    assign w_retire  = RetireEnable & w_run;
    assign RetireErr = 1'b0;
`endif

    always_comb begin
        w_cnt_nxt = r_free_cnt;
        if (!w_run) begin
            w_cnt_nxt = r_free_cnt + CNT_ONE;
        end else if (w_retire && !w_fire) begin
            w_cnt_nxt = r_free_cnt + CNT_ONE;
        end else if (!w_retire && w_fire) begin
            w_cnt_nxt = r_free_cnt - CNT_ONE;
        end
    end

    assign w_we    = ~w_run | w_retire;
    assign w_wdata = w_run ? RetireTag : r_init_cnt;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wr_ptr] <= w_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_INIT;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_init_cnt    <= TAG_FIRST;
            r_free_cnt    <= '0;
            r_alloc_valid <= 1'b0;
            r_init_done   <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_wr_ptr   <= r_wr_ptr + 1'b1;
                    r_init_cnt <= r_init_cnt + 1'b1;
                    r_free_cnt <= w_cnt_nxt;
                    if (r_init_cnt == TAG_LAST) begin
                        r_state       <= S_RUN;
                        r_init_done   <= 1'b1;
                        r_alloc_valid <= (w_cnt_nxt != '0);
                    end
                end
                S_RUN: begin
                    if (w_fire) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end
                    if (w_retire) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                    end
                    r_free_cnt    <= w_cnt_nxt;
                    r_alloc_valid <= (w_cnt_nxt != '0);
                end
                default: begin
                    r_state <= S_INIT;
                end
            endcase
        end
    end

    assign AllocValid = r_alloc_valid;
    assign AllocTag   = r_mem[r_rd_ptr];
    assign FreeCount  = r_free_cnt;
    assign InitDone   = r_init_done;

endmodule
